// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: RAW hazard stalls, branch flushes,
// memory-wait holds and registered EX forwarding selects (forwarding under PIPE_HAZARD_FWD_EN).
module pipe_hazard_ctrl #(
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RFIDX_W-1:0] id_rs1_index,
  input  logic [RFIDX_W-1:0] id_rs2_index,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               id_jalr,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic [RFIDX_W-1:0] ex_rd_index,
  input  logic               m_reg_write,
  input  logic               m_mem_read,
  input  logic [RFIDX_W-1:0] m_rd_index,
  input  logic               wb_reg_write,
  input  logic [RFIDX_W-1:0] wb_rd_index,
  input  logic               bxx_taken,
  input  logic               mem_busy,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic               bxx_flush,
  output logic               pipe_hold,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic [CNT_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c, bxx_flush_c, pipe_hold_c;
  logic hazard, jalr_haz;
  logic ex_rs1, ex_rs2, m_rs1, m_rs2;

  function automatic logic rf_match(input logic               wr,
                                    input logic [RFIDX_W-1:0] rd,
                                    input logic [RFIDX_W-1:0] rs,
                                    input logic               uses,
                                    input logic               valid);
    return valid & wr & (rd != '0) & (rd == rs) & uses;
  endfunction

  assign ex_rs1 = rf_match(ex_reg_write, ex_rd_index, id_rs1_index, id_uses_rs1, id_valid);
  assign ex_rs2 = rf_match(ex_reg_write, ex_rd_index, id_rs2_index, id_uses_rs2, id_valid);
  assign m_rs1  = rf_match(m_reg_write,  m_rd_index,  id_rs1_index, id_uses_rs1, id_valid);
  assign m_rs2  = rf_match(m_reg_write,  m_rd_index,  id_rs2_index, id_uses_rs2, id_valid);

  // JALR reads rs1 in ID, so no forward path can cover an EX/M producer.
  assign jalr_haz = id_jalr & (ex_rs1 | m_rs1);

`ifdef PIPE_HAZARD_FWD_EN
  logic unused_ok;
  assign unused_ok = ^{m_mem_read, wb_reg_write, wb_rd_index};
  assign hazard    = ex_mem_read & (ex_rs1 | ex_rs2);
`else
  logic unused_ok;
  logic wb_rs1, wb_rs2;
  assign unused_ok = ^{m_mem_read, ex_mem_read};
  assign wb_rs1    = rf_match(wb_reg_write, wb_rd_index, id_rs1_index, id_uses_rs1, id_valid);
  assign wb_rs2    = rf_match(wb_reg_write, wb_rd_index, id_rs2_index, id_uses_rs2, id_valid);
  assign hazard    = ex_rs1 | ex_rs2 | m_rs1 | m_rs2 | wb_rs1 | wb_rs2;
`endif

  always_comb begin
    state_d        = state_q;
    flush_pend_d   = flush_pend_q;
    stall_cycles_d = stall_cycles_q;
    pc_stall_c     = 1'b0;
    ifid_stall_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    ifid_flush_c   = 1'b0;
    bxx_flush_c    = 1'b0;
    pipe_hold_c    = 1'b0;

    if (mem_busy) begin
      state_d      = S_HOLD;
      pipe_hold_c  = 1'b1;
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      flush_pend_d = flush_pend_q | bxx_taken;
    end else if (bxx_taken || flush_pend_q) begin
      state_d       = S_FLUSH;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      bxx_flush_c   = 1'b1;
      flush_pend_d  = 1'b0;
    end else if ((state_q != S_FLUSH) && (hazard || jalr_haz)) begin
      state_d       = S_STALL;
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (stall_cycles_q != '1) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
    end else begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      flush_pend_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_pend_q   <= flush_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pc_stall     = rst_n & pc_stall_c;
  assign ifid_stall   = rst_n & ifid_stall_c;
  assign idex_bubble  = rst_n & idex_bubble_c;
  assign ifid_flush   = rst_n & ifid_flush_c;
  assign bxx_flush    = rst_n & bxx_flush_c;
  assign pipe_hold    = rst_n & pipe_hold_c;
  assign stall_cycles = stall_cycles_q;

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic m_hit);
    return ex_hit ? 2'b01 : (m_hit ? 2'b10 : 2'b00);
  endfunction

  // The slot entering EX after a flush is a killed NOP, so it never forwards.
  always_comb begin
    fwd_a_sel_d = fwd_a_sel_q;
    fwd_b_sel_d = fwd_b_sel_q;
    if (!pipe_hold_c) begin
      if (idex_bubble_c || (state_q == S_FLUSH)) begin
        fwd_a_sel_d = '0;
        fwd_b_sel_d = '0;
      end else begin
        fwd_a_sel_d = fwd_pick(ex_rs1 & ~ex_mem_read, m_rs1);
        fwd_b_sel_d = fwd_pick(ex_rs2 & ~ex_mem_read, m_rs2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel_q <= '0;
      fwd_b_sel_q <= '0;
    end else begin
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;
`else
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
`endif

endmodule
